// File: rtl/multicycle_adder_if.sv
// rtl/multicycle_adder_if.sv - operand/result handshake bundle for multicycle_adder
interface multicycle_adder_if #(
    parameter int NBIT       = 32,
    parameter int NBIT_SLICE = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic            cin;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT-1:0] s;
    logic            cout;
    logic            busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, s, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, s, cout, busy
    );
endinterface

// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - NBIT adder built from one NBIT_SLICE slice reused over NBIT/NBIT_SLICE cycles
module multicycle_adder #(
    parameter int NBIT       = 32,
    parameter int NBIT_SLICE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_adder_if.slave   bus
);
    localparam int NUM = NBIT / NBIT_SLICE;
    localparam int KW  = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [NBIT-1:0] a_q, a_d;
    logic [NBIT-1:0] b_q, b_d;
    logic            carry_q, carry_d;
    logic [NBIT-1:0] s_q, s_d;
    logic            cout_q, cout_d;

    logic [NBIT_SLICE-1:0] a_sl, b_sl;
    logic [NBIT_SLICE:0]   slice_res;

    assign a_sl      = a_q[int'(k_q) * NBIT_SLICE +: NBIT_SLICE];
    assign b_sl      = b_q[int'(k_q) * NBIT_SLICE +: NBIT_SLICE];
    assign slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{NBIT_SLICE{1'b0}}, carry_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[int'(k_q) * NBIT_SLICE +: NBIT_SLICE] = slice_res[NBIT_SLICE-1:0];
                carry_d = slice_res[NBIT_SLICE];
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    // Explicit wrap keeps k sane when NUM is not a power of two
                    k_d     = '0;
                    cout_d  = slice_res[NBIT_SLICE];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is masked by rst_n so it reads 0 for the whole reset window
    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// tb/tb_multicycle_adder.sv - directed self-checking bench for multicycle_adder
module tb_multicycle_adder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    multicycle_adder_if #(.NBIT(32), .NBIT_SLICE(4)) bus ();

    multicycle_adder #(.NBIT(32), .NBIT_SLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout in_ready=%b required 1", tag, bus.in_ready);
        end
    endtask

    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                         output logic [31:0] sv, output logic cov, output int lat);
        wait_ready("do_op");
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = cv;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        sv  = bus.s;
        cov = bus.cout;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.a         = $urandom;
            bus.b         = $urandom;
            bus.cin       = 1'($urandom);
            bus.in_valid  = 1'($urandom);
            bus.out_ready = 1'($urandom);
            tick();
            checks++;
            if (bus.s !== 32'h0 || bus.cout !== 1'b0) begin
                errors++;
                $display("FAIL reset_sum s=%h cout=%b required 00000000/0", bus.s, bus.cout);
            end
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags out_valid=%b busy=%b in_ready=%b required 0/0/0",
                         bus.out_valid, bus.busy, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_full_ripple();
        logic [31:0] sv;
        logic        cov;
        int          lat;
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, sv, cov, lat);
        checks++;
        if (sv !== 32'h0000_0000) begin
            errors++;
            $display("FAIL ripple_s s=%h required 00000000", sv);
        end
        checks++;
        if (cov !== 1'b1) begin
            errors++;
            $display("FAIL ripple_cout cout=%b required 1", cov);
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL ripple_latency latency=%0d required 8", lat);
        end
    endtask

    task automatic test_mixed();
        logic [31:0] sv;
        logic        cov;
        int          lat;
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, sv, cov, lat);
        checks++;
        if (sv !== 32'hACF1_3569 || cov !== 1'b0) begin
            errors++;
            $display("FAIL mixed s=%h cout=%b required ACF13569/0", sv, cov);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        wait_ready("bp");
        bus.a = 32'h5; bus.b = 32'h3; bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        bus.a = 32'h1111_1111; bus.b = 32'h1111_1111; bus.cin = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.s !== 32'h8 || bus.cout !== 1'b0 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d s=%h cout=%b out_valid=%b required 00000008/0/1",
                         i, bus.s, bus.cout, bus.out_valid);
            end
            checks++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_ready cycle=%0d in_ready=%b busy=%b required 0/1",
                         i, bus.in_ready, bus.busy);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release in_ready=%b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        checks++;
        if (bus.s !== 32'h2222_2222 || bus.cout !== 1'b0 || lat != 8) begin
            errors++;
            $display("FAIL bp_next s=%h cout=%b latency=%0d required 22222222/0/8",
                     bus.s, bus.cout, lat);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] sv;
        logic        cov;
        int          lat;
        bit          seen;
        wait_ready("mid");
        bus.a = 32'hDEAD_BEEF; bus.b = 32'h0101_0101; bus.cin = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.s !== 32'h0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset s=%h busy=%b in_ready=%b required 00000000/0/0",
                     bus.s, bus.busy, bus.in_ready);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_no_valid out_valid seen=1 required 0");
        end
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, sv, cov, lat);
        checks++;
        if (sv !== 32'h8000_0000 || cov !== 1'b0 || lat != 8) begin
            errors++;
            $display("FAIL mid_next s=%h cout=%b latency=%0d required 80000000/0/8", sv, cov, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] expv;
        int          prev;
        int          hs;
        int          lat;
        wait_ready("b2b");
        bus.a   = $urandom;
        bus.b   = $urandom;
        bus.cin = 1'($urandom);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            wait_ready("b2b_loop");
            hs   = cyc;
            expv = {1'b0, bus.a} + {1'b0, bus.b} + {32'b0, bus.cin};
            if (i > 0) begin
                checks++;
                if (hs - prev != 10) begin
                    errors++;
                    $display("FAIL b2b_spacing op=%0d spacing=%0d required 10", i, hs - prev);
                end
            end
            prev = hs;
            tick();
            bus.a   = $urandom;
            bus.b   = $urandom;
            bus.cin = 1'($urandom);
            lat = 0;
            while (bus.out_valid !== 1'b1 && lat < 50) begin
                tick();
                lat++;
            end
            checks++;
            if ({bus.cout, bus.s} !== expv) begin
                errors++;
                $display("FAIL b2b_sum op=%0d got=%h required %h", i, {bus.cout, bus.s}, expv);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        test_reset();
        test_full_ripple();
        test_mixed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
